// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program stream loader.
// Holds the loader state encoding, unit sizes and small helper functions
// used by the top level and the byte assembler.
package prog_loader_pkg;

    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned HDR_BYTES  = 4;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LINE_W = LINE_BYTES * BYTE_W;
    localparam int unsigned WORD_W = WORD_BYTES * BYTE_W;
    localparam int unsigned IDX_W  = 32;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [2:0] {
        IHDR,
        IDATA,
        IWR,
        DHDR,
        DDATA,
        DWR,
        CKSUM,
        FIN
    } state_t;

    // States in which the loader takes bytes from the stream.
    function automatic logic accepts_bytes(input state_t s);
        return s inside {IHDR, IDATA, DHDR, DDATA, CKSUM};
    endfunction

    // Index of the byte that completes the current unit.
    function automatic logic [CNT_W-1:0] last_byte_idx(input logic line_mode,
                                                       input logic hdr_mode);
        logic [CNT_W-1:0] idx;
        if (line_mode) begin
            idx = CNT_W'(LINE_BYTES - 1);
        end else if (hdr_mode) begin
            idx = CNT_W'(HDR_BYTES - 1);
        end else begin
            idx = CNT_W'(WORD_BYTES - 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/prog_stream_loader_byte_line_assembler.sv
// byte_line_assembler: collects stream bytes into a little-endian unit.
// Bytes enter at the top of a 128-bit shift register, so after N accepts
// the first byte sits at the low end of the top N bytes.
// Ports:
//   clk, reset   clock, async active-high reset
//   in_byte      byte to capture
//   accept       capture strobe (byte transferred this cycle)
//   clear        discard partial unit
//   unit_last    index of the byte completing the unit (3 or 15)
//   data         shift register contents
//   count        bytes captured in the current unit
//   full_c       this accept completes the unit
module byte_line_assembler
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              accept,
    input  logic              clear,
    input  logic [CNT_W-1:0]  unit_last,
    output logic [LINE_W-1:0] data,
    output logic [CNT_W-1:0]  count,
    output logic              full_c
);

    assign full_c = accept && (count == unit_last);

    // Shift in from the top; the count restarts on its own after each unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data  <= '0;
            count <= '0;
        end else if (clear) begin
            data  <= '0;
            count <= '0;
        end else if (accept) begin
            data  <= {in_byte, data[LINE_W-1:BYTE_W]};
            count <= full_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/prog_stream_loader.sv
// prog_stream_loader: turns a byte stream holding an instruction image and a
// data image into imem line writes and dmem word writes, holding `loading`
// high until the load is complete.
// Stream: icount(4B LE) lines*16B dcount(4B LE) words*4B [checksum(4B LE)]
// Optional: define PROG_LOADER_CKSUM_EN to require a 32-bit byte-sum trailer.
// Ports:
//   clk, reset     clock, async active-high reset
//   in_data/in_valid/in_ready   byte stream handshake
//   prog_loadaddr  byte address of the current write
//   prog_loaddata  imem line, or dmem word in [127:96]
//   prog_imem_we   imem line write strobe
//   prog_dmem_we   dmem word write strobe
//   loading        high until done
//   done           sticky completion flag
//   err            sticky error flag (capacity, checksum)
module prog_stream_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_LEN   = 32,
    parameter int unsigned IMEM_LINES = 512,
    parameter int unsigned DMEM_WORDS = 64,
    parameter int unsigned DMEM_BASE  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BYTE_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [ADDR_LEN-1:0] prog_loadaddr,
    output logic [LINE_W-1:0]   prog_loaddata,
    output logic                prog_imem_we,
    output logic                prog_dmem_we,
    output logic                loading,
    output logic                done,
    output logic                err
);

`ifdef PROG_LOADER_CKSUM_EN
    localparam state_t DATA_END = CKSUM;
`else
    localparam state_t DATA_END = FIN;
`endif

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   icount_q, icount_d;
    logic [IDX_W-1:0]   dcount_q, dcount_d;
    logic [IDX_W-1:0]   line_idx_q, line_idx_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;

    logic                in_ready_d;
    logic [ADDR_LEN-1:0] loadaddr_d;
    logic [LINE_W-1:0]   loaddata_d;
    logic                imem_we_d;
    logic                dmem_we_d;
    logic                loading_d;
    logic                done_d;
    logic                err_d;

    logic                accept_c;
    logic                asm_clear_c;
    logic [CNT_W-1:0]    asm_last_c;
    logic [LINE_W-1:0]   asm_data;
    logic [CNT_W-1:0]    asm_count;
    logic                asm_full_c;
    logic [LINE_W-1:0]   unit_c;
    logic [WORD_W-1:0]   word_c;
    logic [ADDR_LEN-1:0] imem_addr_c;
    logic [ADDR_LEN-1:0] dmem_addr_c;
    logic                unused_bits;

    assign accept_c    = in_valid && in_ready;
    assign asm_clear_c = !accepts_bytes(state_q);
    assign asm_last_c  = last_byte_idx(state_q == IDATA, state_q inside {IHDR, DHDR});

    byte_line_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .in_byte   (in_data),
        .accept    (accept_c),
        .clear     (asm_clear_c),
        .unit_last (asm_last_c),
        .data      (asm_data),
        .count     (asm_count),
        .full_c    (asm_full_c)
    );

    // The completed unit includes the byte being accepted this cycle.
    assign unit_c = {in_data, asm_data[LINE_W-1:BYTE_W]};
    assign word_c = unit_c[LINE_W-1 -: WORD_W];

    // Addresses wrap modulo 2^ADDR_LEN.
    assign imem_addr_c = ADDR_LEN'({line_idx_q, 4'b0000});
    assign dmem_addr_c = ADDR_LEN'(64'(DMEM_BASE) + 64'({word_idx_q, 2'b00}));

    // The completion flag carries the framing; the raw count and the byte
    // about to be shifted out are not needed here.
    assign unused_bits = ^{asm_count, asm_data[BYTE_W-1:0]};

`ifdef PROG_LOADER_CKSUM_EN
    logic [WORD_W-1:0] sum_q;

    // Running sum of image payload bytes; headers and trailer excluded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (accept_c && (state_q == IDATA || state_q == DDATA)) begin
            sum_q <= sum_q + WORD_W'(in_data);
        end
    end
`endif

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IHDR;
            icount_q      <= '0;
            dcount_q      <= '0;
            line_idx_q    <= '0;
            word_idx_q    <= '0;
            in_ready      <= 1'b0;
            prog_loadaddr <= '0;
            prog_loaddata <= '0;
            prog_imem_we  <= 1'b0;
            prog_dmem_we  <= 1'b0;
            loading       <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state_q       <= state_d;
            icount_q      <= icount_d;
            dcount_q      <= dcount_d;
            line_idx_q    <= line_idx_d;
            word_idx_q    <= word_idx_d;
            in_ready      <= in_ready_d;
            prog_loadaddr <= loadaddr_d;
            prog_loaddata <= loaddata_d;
            prog_imem_we  <= imem_we_d;
            prog_dmem_we  <= dmem_we_d;
            loading       <= loading_d;
            done          <= done_d;
            err           <= err_d;
        end
    end

    // Next state; write outputs are set up on entry to IWR/DWR so the
    // strobe lands in the bubble cycle.
    always_comb begin
        state_d    = state_q;
        icount_d   = icount_q;
        dcount_d   = dcount_q;
        line_idx_d = line_idx_q;
        word_idx_d = word_idx_q;
        loadaddr_d = prog_loadaddr;
        loaddata_d = prog_loaddata;
        imem_we_d  = 1'b0;
        dmem_we_d  = 1'b0;
        loading_d  = loading;
        done_d     = done;
        err_d      = err;

        case (state_q)
            IHDR: begin
                if (asm_full_c) begin
                    icount_d = word_c;
                    state_d  = (word_c == '0) ? DHDR : IDATA;
                end
            end
            IDATA: begin
                if (asm_full_c) begin
                    state_d    = IWR;
                    loaddata_d = unit_c;
                    loadaddr_d = imem_addr_c;
                    if (line_idx_q < IDX_W'(IMEM_LINES)) begin
                        imem_we_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            IWR: begin
                line_idx_d = line_idx_q + IDX_W'(1);
                state_d    = (line_idx_d != icount_q) ? IDATA : DHDR;
            end
            DHDR: begin
                if (asm_full_c) begin
                    dcount_d = word_c;
                    state_d  = (word_c == '0) ? DATA_END : DDATA;
                end
            end
            DDATA: begin
                if (asm_full_c) begin
                    state_d    = DWR;
                    loaddata_d = {word_c, {(LINE_W - WORD_W){1'b0}}};
                    loadaddr_d = dmem_addr_c;
                    if (word_idx_q < IDX_W'(DMEM_WORDS)) begin
                        dmem_we_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DWR: begin
                word_idx_d = word_idx_q + IDX_W'(1);
                state_d    = (word_idx_d != dcount_q) ? DDATA : DATA_END;
            end
            CKSUM: begin
`ifdef PROG_LOADER_CKSUM_EN
                if (asm_full_c) begin
                    state_d = FIN;
                    if (word_c != sum_q) begin
                        err_d = 1'b1;
                    end
                end
`else
                state_d = FIN;
`endif
            end
            FIN: begin
                done_d    = 1'b1;
                loading_d = 1'b0;
            end
            default: state_d = FIN;
        endcase

        in_ready_d = accepts_bytes(state_d);
    end

endmodule

// File: doc/prog_stream_loader.md
Name: prog_stream_loader

Overview:
- Program loader upstream of the core/memory top level; drives the prog_loading mux inputs of instruction and data memory.
- Consumes a byte stream (valid/ready) carrying an instruction image and a data image.
- Emits 128-bit imem line writes and 32-bit dmem word writes, then signals done.
- Holds `loading` high throughout so the top keeps the pipeline in reset until loading is complete.

Parameters:
- ADDR_LEN, 32, width of prog_loadaddr.
- IMEM_LINES, 512, capacity of instruction memory in 128-bit lines.
- DMEM_WORDS, 64, capacity of data memory in 32-bit words.
- DMEM_BASE, 0, byte address of the first dmem word.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- prog_loadaddr  out  ADDR_LEN  byte address of the current write.
- prog_loaddata  out  128  write data; dmem word on [127:96], other bits 0 for dmem writes.
- prog_imem_we  out  1  one-cycle imem line write strobe.
- prog_dmem_we  out  1  one-cycle dmem word write strobe.
- loading  out  1  high from reset until done.
- done  out  1  load complete, sticky until reset.
- err  out  1  sticky error flag.

Behaviour:
- Reset values: in_ready=0, prog_loadaddr=0, prog_loaddata=0, both we=0, loading=1, done=0, err=0. Internal state is IHDR.
- Byte transfer: a byte is accepted only on a cycle where in_valid && in_ready. Multi-byte fields are little-endian: the first byte lands in bits [7:0].
- IHDR: accept 4 bytes forming the 32-bit icount (number of 128-bit lines).
  - icount==0 -> DHDR.
  - Otherwise -> IDATA.
- IDATA: assemble 16 bytes into a line, byte k at [8k+7:8k]. After the 16th byte -> IWR.
- IWR (one cycle):
  - in_ready=0; prog_imem_we=1; prog_loaddata=line; prog_loadaddr=16*line_idx.
  - Increment line_idx.
  - -> IDATA if lines remain, else DHDR.
- DHDR: accept 4 bytes forming dcount (number of words).
  - dcount==0 -> FIN.
  - Otherwise -> DDATA.
- DDATA: assemble 4 bytes. After the 4th byte -> DWR.
- DWR (one cycle):
  - in_ready=0; prog_dmem_we=1; prog_loaddata={word,96'b0}; prog_loadaddr=DMEM_BASE+4*word_idx.
  - -> DDATA or FIN.
- FIN (CKSUM when the optional feature is enabled): done<=1, loading<=0, in_ready=0 forever after. Further input is ignored.
- in_ready timing: in_ready=1 in IHDR, IDATA, DHDR, DDATA and CKSUM; 0 elsewhere. Exactly one bubble cycle follows each unit.
- Capacity:
  - line_idx>=IMEM_LINES or word_idx>=DMEM_WORDS: the write strobe is suppressed and err<=1.
  - The stream is still consumed to the declared count, so byte framing stays aligned.
- Address arithmetic: prog_loadaddr is computed mod 2^ADDR_LEN; indices are 32-bit.
- Reset mid-load: all outputs immediately return to reset values; any partial line or word is discarded.
- in_valid low mid-unit: assembly stalls with no timeout; the byte count is preserved.

Optional Feature:
- Macro: PROG_LOADER_CKSUM_EN.
- Enabled:
  - A 32-bit running sum of all data bytes (headers excluded), each zero-extended, is accumulated from reset.
  - After the dmem image (or after DHDR when dcount==0), state CKSUM accepts 4 LE bytes.
  - On mismatch err<=1; done still asserts.
- Disabled: no trailer and no checksum logic; err reflects capacity violations only.

Decomposition:
- Package prog_loader_pkg holds:
  - state encoding (IHDR, IDATA, IWR, DHDR, DDATA, DWR, CKSUM, FIN);
  - LINE_BYTES=16 and WORD_BYTES=4;
  - the header length constant (4 bytes).
- One sub-module, byte_line_assembler:
  - inputs: byte plus accept strobe, and clear;
  - outputs: 128-bit little-endian shift register, 5-bit byte count and full flag;
  - full fires at a programmable 4 or 16 bytes.
- Shared by header, line, word and checksum capture.

Test Plan:
- Empty images: stream 00 00 00 00 00 00 00 00 -> no write strobes; done=1, loading=0 two cycles after the last byte; err=0.
- icount=1 with line bytes 0x00..0x0F, then dcount=0 -> single prog_imem_we; loaddata=0x0F0E..0100; addr=0.
- icount=0, dcount=2, words EF BE AD DE, 78 56 34 12 -> dmem_we at addr DMEM_BASE, DMEM_BASE+4; loaddata[127:96]=0xDEADBEEF then 0x12345678; in_ready low exactly on each strobe cycle.
- Backpressure/gaps: random in_valid deassertion during 3 imem lines -> identical writes to the gap-free run; addr 0x00, 0x10, 0x20.
- Overflow with DMEM_WORDS=2, dcount=3 -> two dmem_we strobes, third suppressed; err=1; done=1.
- Reset asserted mid-IDATA after 7 bytes, then a clean image replayed -> first imem write carries the replayed bytes only; with PROG_LOADER_CKSUM_EN, a wrong trailer sets err=1 and done=1.
